// File: rtl/multicycle_pkg.sv
// Shared types and opcode constants for the multicycle instruction sequencer.
package multicycle_pkg;

  localparam int unsigned OPC_W  = 7;
  localparam int unsigned WAIT_W = 8;

  localparam logic [OPC_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OPC_W-1:0] OP_I      = 7'b0010011;
  localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    S_IF, S_ID, S_EXE, S_MEM, S_WB, S_HALT
  } state_e;

  typedef enum logic [2:0] {
    C_ALU, C_LOAD, C_STORE, C_BRANCH, C_ILL
  } cls_e;

  // Map an opcode onto the instruction class that steers the sequencer.
  function automatic cls_e decode_op(input logic [OPC_W-1:0] op);
    cls_e cls;
    case (op)
      OP_R, OP_I: cls = C_ALU;
      OP_LOAD:    cls = C_LOAD;
      OP_STORE:   cls = C_STORE;
      OP_BRANCH:  cls = C_BRANCH;
      default:    cls = C_ILL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory-wait counter; expired_o is high once WAIT_MAX stalled cycles have elapsed.
module mc_wait_timer
  import multicycle_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic cnt_en_i,
  output logic expired_o
);

  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              expired_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + WAIT_W'(1);
    end
  end

  // Flag registered from cnt_d so it tracks cnt_q == WAIT_MAX without a comb path.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= (cnt_d == WAIT_W'(WAIT_MAX));
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/multicycle_seq.sv
// Multicycle IF/ID/EXE/MEM/WB control sequencer with memory timeout and perf counters.
module multicycle_seq
  import multicycle_pkg::*;
#(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             state_if,
  output logic             state_id,
  output logic             state_exe,
  output logic             state_mem,
  output logic             state_wb,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             pc_write,
  output logic             pc_src,
  output logic             reg_write_en,
  output logic             halted,
  output logic             err_timeout,
  output logic             err_illegal,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  state_e           state_q, state_d;
  cls_e             cls_q, cls_d, op_cls;
  logic             tmo_q, tmo_d, ill_q, ill_d;
  logic [CNT_W-1:0] cyc_q, cyc_d, ret_q, ret_d;
  logic             expired, wait_clr, wait_en, retire_c;

  assign op_cls = decode_op(opcode);

  // Next-state logic; the instruction class is latched in ID for EXE and MEM.
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    tmo_d   = tmo_q;
    ill_d   = ill_q;
    case (state_q)
      S_IF: begin
        if (imem_ready) begin
          state_d = S_ID;
        end else if (expired) begin
          state_d = S_HALT;
          tmo_d   = 1'b1;
        end
      end
      S_ID: begin
        cls_d = op_cls;
        if (op_cls == C_ILL) begin
          state_d = S_HALT;
          ill_d   = 1'b1;
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        case (cls_q)
          C_ALU:            state_d = S_WB;
          C_LOAD, C_STORE:  state_d = S_MEM;
          default:          state_d = S_IF;
        endcase
      end
      S_MEM: begin
        if (dmem_ready) begin
          state_d = (cls_q == C_LOAD) ? S_WB : S_IF;
        end else if (expired) begin
          state_d = S_HALT;
          tmo_d   = 1'b1;
        end
      end
      S_WB:    state_d = S_IF;
      default: state_d = S_HALT;
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    state_if     = (state_q == S_IF);
    state_id     = (state_q == S_ID);
    state_exe    = (state_q == S_EXE);
    state_mem    = (state_q == S_MEM);
    state_wb     = (state_q == S_WB);
    halted       = (state_q == S_HALT);
    imem_req     = state_if;
    dmem_req     = state_mem;
    reg_write_en = state_wb;
    retire_c     = state_wb
                 | (state_mem && (cls_q == C_STORE) && dmem_ready)
                 | (state_exe && (cls_q == C_BRANCH));
    pc_write     = retire_c;
    pc_src       = state_exe && (cls_q == C_BRANCH) && zero;
    wait_clr     = (state_d != state_q);
    wait_en      = (state_if && !imem_ready) || (state_mem && !dmem_ready);
  end

  // Saturating performance counters, frozen in HALT.
  always_comb begin
    cyc_d = cyc_q;
    ret_d = ret_q;
    if ((state_q != S_HALT) && (cyc_q != '1)) cyc_d = cyc_q + CNT_W'(1);
    if (retire_c && (ret_q != '1))            ret_d = ret_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IF;
      cls_q   <= C_ALU;
      tmo_q   <= 1'b0;
      ill_q   <= 1'b0;
      cyc_q   <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      tmo_q   <= tmo_d;
      ill_q   <= ill_d;
      cyc_q   <= cyc_d;
      ret_q   <= ret_d;
    end
  end

  mc_wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (wait_clr),
    .cnt_en_i  (wait_en),
    .expired_o (expired)
  );

  assign err_timeout = tmo_q;
  assign err_illegal = ill_q;
  assign cycle_cnt   = cyc_q;
  assign instret_cnt = ret_q;

endmodule
